// File: rtl/axil_stream_write_master.sv
// Stream-to-AXI4-Lite write DMA: buffers incoming words in a small FIFO and
// issues one single-beat write per word to incrementing word addresses.
module axil_stream_write_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  // state | meaning
  // IDLE  | waiting for start
  // WAIT  | waiting for a buffered word
  // SEND  | AW and W in flight, tracked independently
  // RESP  | waiting for the B response
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SEND, S_RESP, S_DONE} state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]        CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]        CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  accepted_cnt;
  logic [LEN_WIDTH-1:0]  sent_cnt;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign wstrb      = 4'hF;
  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign s_ready    = busy && !fifo_full && (accepted_cnt != len_q);
  assign push       = s_valid && s_ready;
  assign pop        = (state == S_WAIT) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      accepted_cnt <= '0;
      sent_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      awaddr       <= '0;
      awvalid      <= 1'b0;
      wdata        <= '0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push) accepted_cnt <= accepted_cnt + LEN_ONE;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q       <= {dst_addr[ADDR_WIDTH-1:2], 2'b00};
            len_q        <= length;
            err          <= 1'b0;
            busy         <= 1'b1;
            accepted_cnt <= '0;
            sent_cnt     <= '0;
            if (length == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!fifo_empty) begin
            wdata   <= mem[rd_ptr];
            awaddr  <= addr_q;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          // A channel counts as finished if it already dropped or handshakes now.
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bvalid && bready) begin
            bready   <= 1'b0;
            if (bresp != 2'b00) err <= 1'b1;
            addr_q   <= addr_q + ADDR_STEP;
            sent_cnt <= sent_cnt + LEN_ONE;
            if ((sent_cnt + LEN_ONE) == len_q) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_stream_write_master.sv
// Directed bench: stream source, stub AXI4-Lite write slave with programmable
// ready delays and error injection, and a handshake monitor.
module tb_axil_stream_write_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dst_addr;
  logic [15:0] length;
  logic        busy, done, err;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  axil_stream_write_master #(.ADDR_WIDTH(32), .FIFO_DEPTH(4), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .err(err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int tests = 0;
  int fails = 0;

  // stream source: one word offered every thr cycles, held until accepted
  logic [31:0] src_q[$];
  logic [31:0] src_tmp;
  int          thr = 1;
  int          phase = 0;
  int          acc_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      src_q.delete();
      s_valid <= 1'b0;
      s_data  <= '0;
      phase   = 0;
    end else begin
      if (s_valid && s_ready) begin
        src_tmp = src_q.pop_front();
        acc_cnt++;
      end
      if (!(s_valid && !s_ready)) begin
        phase = (phase + 1) % thr;
        if (src_q.size() > 0 && phase == 0) begin
          s_valid <= 1'b1;
          s_data  <= src_q[0];
        end else begin
          s_valid <= 1'b0;
        end
      end
    end
  end

  // stub slave
  int   aw_dly = 0;
  int   w_dly = 0;
  int   err_idx = -1;
  int   aw_ctr, w_ctr, b_cnt;
  logic got_aw, got_w, got_aw_n, got_w_n;

  assign awready = awvalid && (aw_ctr >= aw_dly);
  assign wready  = wvalid && (w_ctr >= w_dly);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_ctr <= 0; w_ctr <= 0; b_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
    end else begin
      aw_ctr <= (awvalid && !awready) ? aw_ctr + 1 : 0;
      w_ctr  <= (wvalid && !wready) ? w_ctr + 1 : 0;
      got_aw_n = got_aw | (awvalid & awready);
      got_w_n  = got_w | (wvalid & wready);
      if (got_aw_n && got_w_n && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= (b_cnt == err_idx) ? 2'b10 : 2'b00;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        got_aw <= got_aw_n;
        got_w  <= got_w_n;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_cnt  <= b_cnt + 1;
      end
    end
  end

  // monitor
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  int          done_cnt = 0, rdy_cnt = 0, vld_cnt = 0, stab_viol = 0;
  logic        aw_hold = 1'b0, w_hold = 1'b0;
  logic [31:0] aw_prev, w_prev;

  always @(posedge clk) begin
    if (awvalid && awready) aw_log.push_back(awaddr);
    if (wvalid && wready)   w_log.push_back(wdata);
    if (done)               done_cnt++;
    if (s_ready)            rdy_cnt++;
    if (awvalid || wvalid)  vld_cnt++;
    if (aw_hold && (!awvalid || awaddr !== aw_prev)) stab_viol++;
    if (w_hold && (!wvalid || wdata !== w_prev))     stab_viol++;
    aw_hold = awvalid && !awready;
    w_hold  = wvalid && !wready;
    aw_prev = awaddr;
    w_prev  = wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] l);
    @(negedge clk);
    dst_addr = a;
    length   = l;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic clear_logs();
    aw_log.delete();
    w_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int d0, r0, v0, a0, b0;

  initial begin
    reset = 1'b1; start = 1'b0; dst_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_err", err, 0);       chk("rst_s_ready", s_ready, 0);
    chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0); chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);   chk("rst_wstrb", wstrb, 4'hF);
    reset = 1'b0;
    @(negedge clk);

    // basic 4-word transfer, back-to-back stream
    clear_logs(); d0 = done_cnt;
    src_q = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_start(32'h100, 4);
    chk("t1_busy", busy, 1);
    wait_done("t1_done", 60);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_aw_count", aw_log.size(), 4);
    chk("t1_w_count", w_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_awaddr%0d", i), aw_log[i], 32'h100 + 4 * i);
      chk($sformatf("t1_wdata%0d", i), w_log[i], 32'h11111111 * (i + 1));
    end
    chk("t1_err", err, 0);
    chk("t1_done_pulses", done_cnt - d0, 1);

    // zero length
    clear_logs(); d0 = done_cnt; r0 = rdy_cnt; v0 = vld_cnt;
    do_start(32'h40, 0);
    wait_done("t2_done", 2);
    @(negedge clk);
    chk("t2_busy_after", busy, 0);
    chk("t2_valid_cycles", vld_cnt - v0, 0);
    chk("t2_ready_cycles", rdy_cnt - r0, 0);
    chk("t2_done_pulses", done_cnt - d0, 1);

    // throttled stream, slow slave
    clear_logs(); thr = 3; aw_dly = 3; w_dly = 1; stab_viol = 0;
    src_q = {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
    do_start(32'h0, 3);
    wait_done("t3_done", 200);
    @(negedge clk);
    chk("t3_aw_count", aw_log.size(), 3);
    chk("t3_w_count", w_log.size(), 3);
    chk("t3_awaddr0", aw_log[0], 32'h0);
    chk("t3_awaddr1", aw_log[1], 32'h4);
    chk("t3_awaddr2", aw_log[2], 32'h8);
    chk("t3_wdata0", w_log[0], 32'hA0A0A0A0);
    chk("t3_wdata1", w_log[1], 32'hB1B1B1B1);
    chk("t3_wdata2", w_log[2], 32'hC2C2C2C2);
    chk("t3_stability", stab_viol, 0);
    thr = 1; aw_dly = 0; w_dly = 0;

    // unaligned start address and address wrap
    clear_logs();
    src_q = {32'h5, 32'h6};
    do_start(32'h103, 2);
    wait_done("t4a_done", 60);
    chk("t4a_awaddr0", aw_log[0], 32'h100);
    chk("t4a_awaddr1", aw_log[1], 32'h104);
    @(negedge clk);
    clear_logs();
    src_q = {32'h7, 32'h8};
    do_start(32'hFFFFFFFC, 2);
    wait_done("t4b_done", 60);
    chk("t4b_awaddr0", aw_log[0], 32'hFFFFFFFC);
    chk("t4b_awaddr1", aw_log[1], 32'h00000000);
    @(negedge clk);

    // error response on second of three writes
    clear_logs(); d0 = done_cnt; b0 = b_cnt;
    err_idx = b_cnt + 1;
    src_q = {32'hE0, 32'hE1, 32'hE2};
    do_start(32'h200, 3);
    for (int n = 0; n < 60 && b_cnt < b0 + 2; n++) @(negedge clk);
    chk("t5_two_resp", b_cnt - b0, 2);
    chk("t5_err_set", err, 1);
    wait_done("t5_done", 60);
    @(negedge clk);
    chk("t5_aw_count", aw_log.size(), 3);
    chk("t5_awaddr2", aw_log[2], 32'h208);
    chk("t5_err_sticky", err, 1);
    chk("t5_done_pulses", done_cnt - d0, 1);
    err_idx = -1;
    do_start(32'h0, 0);
    chk("t5_err_cleared", err, 0);
    wait_done("t5b_done", 2);
    @(negedge clk);

    // backpressure: FIFO fills, mid-transfer start ignored
    clear_logs(); d0 = done_cnt; a0 = acc_cnt; aw_dly = 20;
    for (int i = 0; i < 8; i++) src_q.push_back(32'hD000 + i);
    do_start(32'h300, 8);
    repeat (12) @(negedge clk);
    chk("t6_s_ready_low", s_ready, 0);
    chk("t6_accepted_while_stalled", acc_cnt - a0, 5);
    do_start(32'h900, 2);
    wait_done("t6_done", 400);
    @(negedge clk);
    chk("t6_aw_count", aw_log.size(), 8);
    chk("t6_accepted", acc_cnt - a0, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6_awaddr%0d", i), aw_log[i], 32'h300 + 4 * i);
      chk($sformatf("t6_wdata%0d", i), w_log[i], 32'hD000 + i);
    end
    chk("t6_done_pulses", done_cnt - d0, 1);
    aw_dly = 0;

    // reset mid-transfer
    clear_logs();
    for (int i = 0; i < 8; i++) src_q.push_back(32'hF000 + i);
    do_start(32'h400, 8);
    repeat (6) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("t7_busy", busy, 0);       chk("t7_done", done, 0);
    chk("t7_s_ready", s_ready, 0); chk("t7_awvalid", awvalid, 0);
    chk("t7_wvalid", wvalid, 0);   chk("t7_bready", bready, 0);
    chk("t7_awaddr", awaddr, 0);   chk("t7_wdata", wdata, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_stream_write_master.md
Name: axil_stream_write_master

Overview:
- DMA write engine sitting directly upstream of the AXI4-Lite RAM slave on the write channels (AW/W/B).
- Accepts a 32-bit valid/ready word stream (e.g. QSPI read data), buffers it in a small FIFO and issues one single-beat AXI4-Lite write per word.
- Writes land at incrementing word addresses starting at a programmed destination; reports busy/done/error to the control logic.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- FIFO_DEPTH, 4, input buffer depth in words; power of 2, >= 2.
- LEN_WIDTH, 16, width of the transfer length counter (words).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse, begins transfer; ignored while busy=1.
- dst_addr  input  ADDR_WIDTH  byte start address, sampled on start; bits [1:0] forced to 0.
- length  input  LEN_WIDTH  number of words, sampled on start.
- busy  output  1  high from the cycle after an accepted start until the done cycle inclusive.
- done  output  1  one-cycle pulse when the last B response is received (or immediately for length 0).
- err  output  1  sticky; set on any bresp != 2'b00; cleared on the next accepted start.
- s_data  input  32  stream data word.
- s_valid  input  1  stream valid.
- s_ready  output  1  stream ready.
- awaddr  output  ADDR_WIDTH  write address.
- awvalid  output  1  write address valid.
- awready  input  1  write address ready.
- wdata  output  32  write data.
- wstrb  output  4  always 4'hF.
- wvalid  output  1  write data valid.
- wready  input  1  write data ready.
- bresp  input  2  write response.
- bvalid  input  1  write response valid.
- bready  output  1  write response ready.

Behaviour:
- Reset (asynchronous, active-high) forces all outputs to 0: busy, done, err, s_ready, awvalid, wvalid, bready, awaddr, wdata. FIFO is emptied and counters are cleared. wstrb is constant 4'hF. Reset mid-transfer aborts it with no done pulse.
- Input side: s_ready = busy && !fifo_full && (accepted_cnt != len_q). A word is accepted when s_valid && s_ready. The stream is never accepted while idle, and no more than length words are accepted.
- FIFO: simultaneous push and pop on a full or empty FIFO is legal; the count is unchanged on push+pop.
- FSM states and transitions:
  - IDLE: on start, latch addr_q = {dst_addr[ADDR_WIDTH-1:2],2'b00}, len_q = length, and clear err. If length == 0, go to DONE; otherwise go to WAIT.
  - WAIT: when the FIFO is non-empty, pop the head into wdata, set awaddr = addr_q, assert awvalid=1 and wvalid=1, go to SEND.
  - SEND: AW and W handshakes are tracked independently. awvalid drops in the cycle after awvalid&&awready; wvalid drops in the cycle after wvalid&&wready. Both may complete in the same cycle, in either order, or with any number of cycles between them. awaddr and wdata are held stable while their valid is high. Once both have completed, assert bready=1 and go to RESP.
  - RESP: on bvalid&&bready, drop bready, set err if bresp != 0, addr_q += 4 (wraps modulo 2^ADDR_WIDTH), sent_cnt += 1. If sent_cnt+1 == len_q, go to DONE; otherwise go to WAIT.
  - DONE: done=1 for exactly one cycle, busy deasserts in the next cycle, return to IDLE.
- At most one write is outstanding. Minimum per-word cost is 3 cycles with a zero-wait slave.
- An error response does not abort the transfer; all length words are still written.
- A start pulse during busy has no effect on any state.

Test Plan:
- Reset, then start with dst_addr=0x100, length=4, stream 0x11111111..0x44444444 back-to-back, paired with the RAM slave → RAM words 64..67 hold those values, done pulses once, err=0, exactly 4 AW and 4 W handshakes observed.
- length=0 with start → done pulses within 2 cycles, no awvalid/wvalid ever asserted, s_ready stays 0.
- Throttled stream (s_valid 1 in 3 cycles) plus a stub slave delaying awready 3 cycles and wready 1 cycle → awaddr/wdata stable while valid, every word written once, addresses 0x0,0x4,0x8.
- dst_addr=0x103, length=2 → awaddr 0x100 then 0x104. Then dst_addr=0xFFFFFFFC, length=2 with ADDR_WIDTH=32 → awaddr 0xFFFFFFFC then 0x00000000.
- Stub slave returning bresp=2'b10 on the second of 3 writes → err=1 after that response, third write still issued, done pulses; next start clears err.
- FIFO_DEPTH=4, length=8, slave holds awready low for 20 cycles → s_ready drops after 4 words are buffered, no word lost or duplicated. A start pulse mid-transfer is ignored. Reset asserted mid-transfer returns all outputs to 0 and no done pulse occurs.
